// File: rtl/nbcac_pkg.sv
// Shared definitions for the NBCAC stream decoder.
//   fib_w        : wire weight W(i), with W(1)=1, W(2)=2, W(i)=W(i-1)+W(i-2)
//   w_total      : sum of W(1..n), the largest value an n-wire codeword can decode to
//   sum_width    : bits needed to hold any n-wire sum, plus one bit of headroom
//   params_legal : legal parameter ranges for the decoder
package nbcac_pkg;

    function automatic int unsigned fib_w(input int i);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 1;
        b = 2;
        if (i <= 1) return 1;
        for (int k = 3; k <= i; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic int unsigned w_total(input int n);
        int unsigned s;
        s = 0;
        for (int i = 1; i <= n; i++) s = s + fib_w(i);
        return s;
    endfunction

    function automatic int sum_width(input int n);
        return $clog2(w_total(n)) + 1;
    endfunction

    function automatic bit params_legal(input int n, input int k, input int e);
        return (n >= 4) && (n <= 32) && (k >= 2) && (k <= 24) && (e >= 1);
    endfunction

endpackage

// File: rtl/nbcac_wsum.sv
// Combinational Fibonacci-weighted sum over a slice of code wires.
//   i_wires : slice of the codeword; bit j carries wire number BASE+j
//   o_sum   : sum of W(BASE+j) over every set bit, SUM_W bits wide
module nbcac_wsum
    import nbcac_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int BASE  = 1,
    parameter int SUM_W = 16
) (
    input  logic [WIDTH-1:0] i_wires,
    output logic [SUM_W-1:0] o_sum
);

    always_comb begin
        o_sum = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (i_wires[j]) o_sum = o_sum + SUM_W'(fib_w(BASE + j));
        end
    end

endmodule

// File: rtl/nbcac_decoder_stream.sv
// Two-stage elastic NBCAC decoder with an overflow flag and a saturating error counter.
//   clock     : rising-edge clock
//   rst       : synchronous active-high reset, flushes both stages
//   codein    : received codeword, wire i on bit i (1-based)
//   in_valid  : codein is valid this cycle
//   in_ready  : block accepts codein this cycle
//   dataout   : decoded word (low K_BITS of the weighted sum)
//   out_valid : dataout/out_err are valid
//   out_ready : downstream accepts the output word
//   out_err   : weighted sum did not fit in K_BITS
//   err_clr   : synchronous clear of err_count, wins over an increment
//   err_count : saturating count of output transfers with out_err=1
module nbcac_decoder_stream
    import nbcac_pkg::*;
#(
    parameter int N_WIRES  = 20,
    parameter int K_BITS   = 14,
    parameter int ERRCNT_W = 16
) (
    input  logic                clock,
    input  logic                rst,
    input  logic [N_WIRES:1]    codein,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [K_BITS-1:0]   dataout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_err,
    input  logic                err_clr,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int SUM_W = sum_width(N_WIRES);
    localparam int LO_N  = N_WIRES / 2;
    localparam int HI_N  = N_WIRES - LO_N;
    // Widen the sum when K_BITS exceeds it so the dataout slice is always in range.
    localparam int EXT_W = (SUM_W > K_BITS) ? SUM_W : K_BITS;

    generate
        if (!params_legal(N_WIRES, K_BITS, ERRCNT_W)) begin : g_bad_params
            $error("nbcac_decoder_stream: illegal N_WIRES/K_BITS/ERRCNT_W");
        end
    endgenerate

    function automatic logic is_over(input logic [EXT_W-1:0] v);
        logic f;
        f = 1'b0;
        for (int i = K_BITS; i < EXT_W; i++) f = f | v[i];
        return f;
    endfunction

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] c);
        return (&c) ? c : c + ERRCNT_W'(1);
    endfunction

    logic [SUM_W-1:0]    w_sum_lo;
    logic [SUM_W-1:0]    w_sum_hi;
    logic [SUM_W-1:0]    w_sum_p1;
    logic [EXT_W-1:0]    w_sum_ext;
    logic                w_adv1;
    logic                w_adv2;

    logic [SUM_W-1:0]    r_sum_lo_p1;
    logic [SUM_W-1:0]    r_sum_hi_p1;
    logic                r_vld_p1;
    logic                r_vld_p2;
    logic [K_BITS-1:0]   r_data_p2;
    logic                r_err_p2;
    logic [ERRCNT_W-1:0] r_errcnt;

    nbcac_wsum #(.WIDTH(LO_N), .BASE(1), .SUM_W(SUM_W)) u_wsum_lo (
        .i_wires (codein[LO_N:1]),
        .o_sum   (w_sum_lo)
    );

    nbcac_wsum #(.WIDTH(HI_N), .BASE(LO_N + 1), .SUM_W(SUM_W)) u_wsum_hi (
        .i_wires (codein[N_WIRES:LO_N+1]),
        .o_sum   (w_sum_hi)
    );

    // A stage loads when it is empty or its current word is leaving this cycle.
    assign w_adv2   = !r_vld_p2 || out_ready;
    assign w_adv1   = !r_vld_p1 || w_adv2;
    assign in_ready = !rst && w_adv1;

    // ---- stage 1: half sums ----
    always_ff @(posedge clock) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv1) begin
            r_vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (w_adv1 && in_valid) begin
            r_sum_lo_p1 <= w_sum_lo;
            r_sum_hi_p1 <= w_sum_hi;
        end
    end

    assign w_sum_p1  = r_sum_lo_p1 + r_sum_hi_p1;
    assign w_sum_ext = EXT_W'(w_sum_p1);

    // ---- stage 2: final sum, overflow check, output register ----
    always_ff @(posedge clock) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_err_p2  <= 1'b0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_sum_ext[K_BITS-1:0];
                r_err_p2  <= is_over(w_sum_ext);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst || err_clr) begin
            r_errcnt <= '0;
        end else if (r_vld_p2 && out_ready && r_err_p2) begin
            r_errcnt <= sat_inc(r_errcnt);
        end
    end

    assign dataout   = r_data_p2;
    assign out_err   = r_err_p2;
    assign out_valid = r_vld_p2;
    assign err_count = r_errcnt;

endmodule

// File: tb/tb_nbcac_decoder_stream.sv
// Directed self-checking bench for nbcac_decoder_stream: a default-parameter
// instance for decode/stream/reset behaviour and an ERRCNT_W=2 instance for
// counter saturation. Inputs change and outputs are sampled on the falling edge.
module tb_nbcac_decoder_stream;

    logic        clock;
    logic        rst;
    logic [20:1] codein;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] dataout;
    logic        out_valid;
    logic        out_ready;
    logic        out_err;
    logic        err_clr;
    logic [15:0] err_count;

    logic [20:1] codein2;
    logic        in_valid2;
    logic        in_ready2;
    logic [13:0] dataout2;
    logic        out_valid2;
    logic        out_ready2;
    logic        out_err2;
    logic        err_clr2;
    logic [1:0]  err_count2;

    int n_total = 0;
    int n_bad   = 0;

    // Hand-computed decodes (W(1..20) = 1,2,3,5,...,10946).
    logic [19:0] codes [8] = '{20'h00001, 20'h80000, 20'h80001, 20'hFFFFF,
                               20'hAAAAA, 20'h55555, 20'hA4882, 20'hA4884};
    int          exp_d [8] = '{1, 10946, 10947, 12271, 1326, 10945, 16383, 0};
    logic        exp_e [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    nbcac_decoder_stream dut (
        .clock     (clock),
        .rst       (rst),
        .codein    (codein),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    nbcac_decoder_stream #(.ERRCNT_W(2)) dut2 (
        .clock     (clock),
        .rst       (rst),
        .codein    (codein2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .dataout   (dataout2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_err   (out_err2),
        .err_clr   (err_clr2),
        .err_count (err_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // One isolated word with out_ready high; starts and ends on a falling edge.
    task automatic xfer1(input string tag, input int k, input logic clr, input int exp_cnt);
        codein   = codes[k];
        in_valid = 1'b1;
        #1;
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        check_eq({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clock);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(dataout), 32'(exp_d[k]));
        check_eq({tag, "_err"}, 32'(out_err), 32'(exp_e[k]));
        err_clr = clr;
        @(negedge clock);
        err_clr = 1'b0;
        check_eq({tag, "_drained"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_errcnt"}, 32'(err_count), 32'(exp_cnt));
    endtask

    initial begin
        int          idx;
        int          rcv;
        bit          stalled;
        logic [13:0] held_d;
        logic        held_e;

        rst = 1'b1;
        codein = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        codein2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1; err_clr2 = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_dataout", 32'(dataout), 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        @(negedge clock);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Isolated words, including the 16383/16384 overflow boundary
        xfer1("w00001", 0, 1'b0, 0);
        xfer1("w80000", 1, 1'b0, 0);
        xfer1("w80001", 2, 1'b0, 0);
        xfer1("wFFFFF", 3, 1'b0, 1);
        xfer1("wAAAAA", 4, 1'b0, 2);
        xfer1("w55555", 5, 1'b0, 2);
        xfer1("w16383", 6, 1'b0, 2);
        xfer1("w16384", 7, 1'b0, 3);
        // Clear in the same cycle as an erroring output transfer
        xfer1("wclr", 3, 1'b1, 0);

        // Back-to-back stream of 8 words, out_ready low in cycles 3..6
        idx = 0; rcv = 0; stalled = 0; held_d = '0; held_e = 1'b0;
        for (int c = 0; c < 18; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (idx < 8);
            codein    = (idx < 8) ? codes[idx] : 20'h0;
            #1;
            check_eq($sformatf("s_in_ready_c%0d", c), 32'(in_ready), 32'(!(c >= 3 && c <= 6)));
            if (stalled) begin
                check_eq($sformatf("s_hold_valid_c%0d", c), 32'(out_valid), 32'd1);
                check_eq($sformatf("s_hold_data_c%0d", c), 32'(dataout), 32'(held_d));
                check_eq($sformatf("s_hold_err_c%0d", c), 32'(out_err), 32'(held_e));
            end
            stalled = 0;
            if (out_valid) begin
                if (out_ready) begin
                    if (rcv < 8) begin
                        check_eq($sformatf("s_data_w%0d", rcv), 32'(dataout), 32'(exp_d[rcv]));
                        check_eq($sformatf("s_err_w%0d", rcv), 32'(out_err), 32'(exp_e[rcv]));
                    end
                    rcv++;
                end else begin
                    stalled = 1;
                    held_d  = dataout;
                    held_e  = out_err;
                end
            end
            if (in_valid && in_ready) idx++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check_eq("s_accepted", 32'(idx), 32'd8);
        check_eq("s_delivered", 32'(rcv), 32'd8);
        check_eq("s_errcnt", 32'(err_count), 32'd3);

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        codein    = codes[0];
        @(negedge clock);
        codein    = codes[1];
        @(negedge clock);
        in_valid  = 1'b0;
        #1;
        check_eq("f_full_valid", 32'(out_valid), 32'd1);
        check_eq("f_full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("f_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        check_eq("f_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("f_rst_dataout", 32'(dataout), 32'd0);
        check_eq("f_rst_errcnt", 32'(err_count), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("f_post_in_ready", 32'(in_ready), 32'd1);
        check_eq("f_post_out_valid", 32'(out_valid), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check_eq($sformatf("f_no_stale_c%0d", c), 32'(out_valid), 32'd0);
        end

        // ERRCNT_W=2 instance: five errors saturate at 3
        in_valid2 = 1'b1;
        codein2   = 20'hFFFFF;
        repeat (5) @(negedge clock);
        in_valid2 = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("sat_errcnt", 32'(err_count2), 32'd3);
        check_eq("sat_drained", 32'(out_valid2), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/nbcac_decoder_stream.md
NBCAC_DECODER_STREAM -- requirements
Module: nbcac_decoder_stream

Interface
REQ-001 SHALL have parameter N_WIRES, default 20, meaning the number of code wires on the bus (legal range 4..32).
REQ-002 SHALL have parameter K_BITS, default 14, meaning the decoded data width (legal range 2..24).
REQ-003 SHALL have parameter ERRCNT_W, default 16, meaning the error-counter width.
REQ-004 SHALL have port clock, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-006 SHALL have port codein, input, [N_WIRES:1], the received NBCAC codeword.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning codein is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the block accepts codein this cycle.
REQ-009 SHALL have port dataout, output, [K_BITS-1:0], the decoded word.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning dataout/out_err are valid.
REQ-011 SHALL have port out_ready, input, 1 bit, the downstream accept.
REQ-012 SHALL have port out_err, output, 1 bit, the overflow flag of the word on dataout.
REQ-013 SHALL have port err_clr, input, 1 bit, a synchronous clear of err_count.
REQ-014 SHALL have port err_count, output, [ERRCNT_W-1:0], the number of accepted-at-output words with out_err=1.

Function
REQ-015 SHALL decode by Fibonacci-weighted sum: value = sum of codein[i]*W[i], i=1..N_WIRES, with W[1]=1, W[2]=2, W[i]=W[i-1]+W[i-2].
REQ-016 SHALL compute the sum at full width SUM_W = ceil(log2(sum of all W))+1, with no truncation before the overflow check.
REQ-017 SHALL assert out_err when value > 2^K_BITS-1; dataout then carries value[K_BITS-1:0].
REQ-018 SHALL be a two-stage elastic pipeline: S1 registers partial sums of wires 1..N_WIRES/2 and N_WIRES/2+1..N_WIRES; S2 registers the final sum, dataout and out_err.
REQ-019 SHALL transfer a word on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-020 SHALL have a latency of 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-021 SHALL sustain a throughput of 1 word/cycle with out_ready held high.
REQ-022 SHALL advance each stage when that stage is empty or the next stage is advancing/being drained; in_ready = !S1_valid || S1 advances (combinational from out_ready; no bubble insertion).
REQ-023 SHALL hold dataout, out_err and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL never drop or duplicate a word; ordering is strictly FIFO.
REQ-025 SHALL increment err_count by 1 on each output transfer with out_err=1, saturating at 2^ERRCNT_W-1.
REQ-026 SHALL give err_clr priority over a simultaneous increment; the count is 0 on the next cycle.
REQ-027 SHALL ignore codein when in_valid=0; the input value is don't-care.

Reset
REQ-028 SHALL, with rst=1 at a rising edge, clear S1/S2 valid bits, dataout=0, out_err=0, out_valid=0, err_count=0 on that edge.
REQ-029 SHALL drive in_ready=0 while rst=1 and SHALL discard any in-flight words.
REQ-030 SHALL, in the first cycle after rst deasserts, drive in_ready=1 and out_valid=0.

Structure
REQ-031 SHALL place the weight function W(i), the SUM_W calculation function and the parameter legality checks in shared package nbcac_pkg.
REQ-032 SHALL use a single sub-module nbcac_wsum (combinational weighted sum over a wire slice with a base index), instantiated twice in S1.
REQ-033 SHALL fit within 120-400 lines of RTL total.

Verification
REQ-034 SHALL verify: default parameters, codein=20'h00001, out_ready=1 -> dataout=1 two cycles later, out_err=0.
REQ-035 SHALL verify: codein=20'h80000 -> dataout=10946; codein=20'h80001 -> dataout=10947; both with out_err=0.
REQ-036 SHALL verify: codein=20'hFFFFF (sum 28655) -> out_err=1, dataout=28655 mod 16384 = 12271, err_count increments to 1.
REQ-037 SHALL verify: a back-to-back stream of 8 words with out_ready low for cycles 3-6 -> in_ready low after both stages fill, the outputs held stable, and all 8 words delivered in order with none lost.
REQ-038 SHALL verify: err_clr asserted in the same cycle as an erroring output transfer -> err_count=0; with ERRCNT_W=2 and 5 errors -> err_count=3.
REQ-039 SHALL verify: rst asserted with 2 words in flight -> out_valid=0 on the next cycle, no stale word emitted, and in_ready=1 in the cycle after rst drops.
